// File: rtl/button_bcd_counter_if.sv
// Button/display bundle for the BCD push-button counter.
// The state fields carry each debouncer's FSM state: 0 idle, 1 press_wait, 2 held, 3 release_wait.
interface button_bcd_counter_if;
   logic        btn_up;
   logic        btn_down;
   logic        clear;
   logic [15:0] Data;
   logic        wrap;
   logic [1:0]  up_state;
   logic [1:0]  down_state;

   modport master (
      output btn_up, btn_down, clear,
      input  Data, wrap, up_state, down_state
   );

   modport slave (
      input  btn_up, btn_down, clear,
      output Data, wrap, up_state, down_state
   );
endinterface

// File: rtl/button_bcd_counter.sv
// Two debounced push-buttons stepping a 4-digit packed BCD counter up or down,
// with synchronous clear and a one-cycle roll-over pulse.
module bcd_btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       raw,
   output logic       press,
   output logic [1:0] state_dbg
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          press_q, press_d;

   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

   // cnt counts consecutive synced cycles at the new level, including the entry cycle.
   always_comb begin
      sync1_d = raw;
      sync2_d = sync1_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (sync2_q) begin
               state_d = PRESS_WAIT;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d = '0;
            end
         end
         PRESS_WAIT: begin
            if (!sync2_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q >= CNT_LAST) begin
               state_d = HELD;
               cnt_d   = '0;
               press_d = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         HELD: begin
            if (!sync2_q) begin
               state_d = RELEASE_WAIT;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d = '0;
            end
         end
         RELEASE_WAIT: begin
            if (sync2_q) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q >= CNT_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= IDLE;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press     = press_q;
   assign state_dbg = state_q;
endmodule

module button_bcd_counter #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic                 CLK_in,
   input  logic                 RST_n,
   button_bcd_counter_if.slave  bus
);
   logic        up_evt, dn_evt;
   logic [15:0] data_q, data_d;
   logic        wrap_q, wrap_d;
   logic [15:0] inc_val, dec_val;
   logic        inc_c, dec_b;

   bcd_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
      .clk       (CLK_in),
      .rst_n     (RST_n),
      .raw       (bus.btn_up),
      .press     (up_evt),
      .state_dbg (bus.up_state)
   );

   bcd_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
      .clk       (CLK_in),
      .rst_n     (RST_n),
      .raw       (bus.btn_down),
      .press     (dn_evt),
      .state_dbg (bus.down_state)
   );

   // Ripple carry/borrow across digits; a carry or borrow out of the top digit is the roll-over.
   always_comb begin
      inc_val = data_q;
      dec_val = data_q;
      inc_c   = 1'b1;
      dec_b   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (inc_c) begin
            if (data_q[i*4 +: 4] == 4'd9) begin
               inc_val[i*4 +: 4] = 4'd0;
            end else begin
               inc_val[i*4 +: 4] = data_q[i*4 +: 4] + 4'd1;
               inc_c = 1'b0;
            end
         end
         if (dec_b) begin
            if (data_q[i*4 +: 4] == 4'd0) begin
               dec_val[i*4 +: 4] = 4'd9;
            end else begin
               dec_val[i*4 +: 4] = data_q[i*4 +: 4] - 4'd1;
               dec_b = 1'b0;
            end
         end
      end
   end

   always_comb begin
      data_d = data_q;
      wrap_d = 1'b0;
      if (bus.clear) begin
         data_d = 16'h0000;
      end else if (up_evt && !dn_evt) begin
         data_d = inc_val;
         wrap_d = inc_c;
      end else if (dn_evt && !up_evt) begin
         data_d = dec_val;
         wrap_d = dec_b;
      end
   end

   always_ff @(posedge CLK_in or negedge RST_n) begin
      if (!RST_n) begin
         data_q <= 16'h0000;
         wrap_q <= 1'b0;
      end else begin
         data_q <= data_d;
         wrap_q <= wrap_d;
      end
   end

   assign bus.Data = data_q;
   assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_button_bcd_counter.sv
// Bench for button_bcd_counter with a 4-cycle debounce: directed scenarios plus a
// randomized press/bounce sequence checked against an integer count model.
module tb_button_bcd_counter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   wrap_cycles = 0;
  int   model = 0;

  button_bcd_counter_if bus ();

  button_bcd_counter #(.DEBOUNCE_CYCLES(N)) dut (
    .CLK_in (clk),
    .RST_n  (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.wrap === 1'b1) wrap_cycles++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] to_bcd(input int v);
    to_bcd = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b0;
    bus.clear = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model = 0;
  endtask

  // Clean press of the selected button(s), then a release long enough to reach idle.
  task automatic press(input bit up, input bit dn);
    @(negedge clk);
    bus.btn_up = up;
    bus.btn_down = dn;
    repeat (N + 4) @(negedge clk);
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b0;
    repeat (N + 5) @(negedge clk);
  endtask

  task automatic bounce_press(input bit up, input bit dn);
    int g;
    g = $urandom_range(0, 3);
    for (int i = 0; i < g; i++) begin
      @(negedge clk);
      bus.btn_up = up;
      bus.btn_down = dn;
      repeat ($urandom_range(1, N - 1) - 1) @(negedge clk);
      @(negedge clk);
      bus.btn_up = 1'b0;
      bus.btn_down = 1'b0;
      repeat ($urandom_range(1, 3) - 1) @(negedge clk);
    end
    @(negedge clk);
    bus.btn_up = up;
    bus.btn_down = dn;
    repeat (N + 4) @(negedge clk);
    g = $urandom_range(0, 3);
    for (int i = 0; i < g; i++) begin
      bus.btn_up = 1'b0;
      bus.btn_down = 1'b0;
      repeat ($urandom_range(1, N - 1)) @(negedge clk);
      bus.btn_up = up;
      bus.btn_down = dn;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b0;
    repeat (N + 5) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b0;
    bus.clear = 1'b0;
    #1;
    total++; if (bus.Data !== 16'h0000) begin bad++; $display("FAIL reset_data: got %h exp 0000", bus.Data); end
    total++; if (bus.wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap: got %b exp 0", bus.wrap); end
    total++; if (bus.up_state !== 2'd0) begin bad++; $display("FAIL reset_up_state: got %0d exp 0", bus.up_state); end
    total++; if (bus.down_state !== 2'd0) begin bad++; $display("FAIL reset_down_state: got %0d exp 0", bus.down_state); end
    do_reset();
  endtask

  task automatic test_single_press();
    int lat;
    int changes;
    int w0;
    logic [15:0] prev;
    do_reset();
    lat = -1;
    changes = 0;
    prev = 16'h0000;
    w0 = wrap_cycles;
    @(negedge clk);
    bus.btn_up = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      if (bus.Data !== prev) begin
        changes++;
        if (lat < 0) lat = e;
        prev = bus.Data;
      end
    end
    @(negedge clk);
    bus.btn_up = 1'b0;
    repeat (N + 5) @(negedge clk);
    total++; if (lat < 1 || lat > N + 4) begin bad++; $display("FAIL single_latency: got %0d edges exp 1..%0d", lat, N + 4); end
    total++; if (bus.Data !== 16'h0001) begin bad++; $display("FAIL single_data: got %h exp 0001", bus.Data); end
    total++; if (changes !== 1) begin bad++; $display("FAIL single_changes: got %0d exp 1", changes); end
    total++; if (wrap_cycles - w0 !== 0) begin bad++; $display("FAIL single_wrap: got %0d exp 0", wrap_cycles - w0); end
    total++; if (bus.up_state !== 2'd0) begin bad++; $display("FAIL single_idle: got %0d exp 0", bus.up_state); end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.btn_up = (i % 2 == 0);
    end
    @(negedge clk);
    bus.btn_up = 1'b0;
    repeat (N + 6) @(negedge clk);
    total++; if (bus.Data !== 16'h0000) begin bad++; $display("FAIL bounce_data: got %h exp 0000", bus.Data); end
    total++; if (bus.up_state !== 2'd0) begin bad++; $display("FAIL bounce_idle: got %0d exp 0", bus.up_state); end
  endtask

  task automatic test_carry();
    int w0;
    do_reset();
    w0 = wrap_cycles;
    repeat (999) press(1'b1, 1'b0);
    total++; if (bus.Data !== 16'h0999) begin bad++; $display("FAIL preload_999: got %h exp 0999", bus.Data); end
    press(1'b1, 1'b0);
    total++; if (bus.Data !== 16'h1000) begin bad++; $display("FAIL carry_1000: got %h exp 1000", bus.Data); end
    total++; if (wrap_cycles - w0 !== 0) begin bad++; $display("FAIL carry_nowrap: got %0d exp 0", wrap_cycles - w0); end
    do_reset();
    w0 = wrap_cycles;
    press(1'b0, 1'b1);
    total++; if (bus.Data !== 16'h9999) begin bad++; $display("FAIL borrow_9999: got %h exp 9999", bus.Data); end
    total++; if (wrap_cycles - w0 !== 1) begin bad++; $display("FAIL borrow_wrap: got %0d cycles exp 1", wrap_cycles - w0); end
    w0 = wrap_cycles;
    press(1'b1, 1'b0);
    total++; if (bus.Data !== 16'h0000) begin bad++; $display("FAIL carry_0000: got %h exp 0000", bus.Data); end
    total++; if (wrap_cycles - w0 !== 1) begin bad++; $display("FAIL carry_wrap: got %0d cycles exp 1", wrap_cycles - w0); end
  endtask

  task automatic test_simultaneous();
    int w0;
    bit stray;
    do_reset();
    repeat (42) press(1'b1, 1'b0);
    total++; if (bus.Data !== 16'h0042) begin bad++; $display("FAIL preload_42: got %h exp 0042", bus.Data); end
    w0 = wrap_cycles;
    stray = 1'b0;
    @(negedge clk);
    bus.btn_up = 1'b1;
    bus.btn_down = 1'b1;
    for (int i = 0; i < N + 6; i++) begin
      @(negedge clk);
      if (bus.Data !== 16'h0042) stray = 1'b1;
    end
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b0;
    repeat (N + 5) @(negedge clk);
    total++; if (stray !== 1'b0 || bus.Data !== 16'h0042) begin bad++; $display("FAIL both_hold: got %h stray=%0d exp 0042 stray=0", bus.Data, stray); end
    total++; if (wrap_cycles - w0 !== 0) begin bad++; $display("FAIL both_wrap: got %0d exp 0", wrap_cycles - w0); end
    press(1'b1, 1'b0);
    total++; if (bus.Data !== 16'h0043) begin bad++; $display("FAIL after_both: got %h exp 0043", bus.Data); end
    // clear held across the whole window in which the up event lands
    w0 = wrap_cycles;
    stray = 1'b0;
    @(negedge clk);
    bus.btn_up = 1'b1;
    repeat (2) @(negedge clk);
    bus.clear = 1'b1;
    for (int i = 0; i < N + 4; i++) begin
      @(negedge clk);
      if (bus.Data !== 16'h0000) stray = 1'b1;
    end
    bus.clear = 1'b0;
    bus.btn_up = 1'b0;
    repeat (N + 5) @(negedge clk);
    total++; if (stray !== 1'b0 || bus.Data !== 16'h0000) begin bad++; $display("FAIL clear_override: got %h stray=%0d exp 0000 stray=0", bus.Data, stray); end
    total++; if (wrap_cycles - w0 !== 0) begin bad++; $display("FAIL clear_wrap: got %0d exp 0", wrap_cycles - w0); end
    press(1'b1, 1'b0);
    total++; if (bus.Data !== 16'h0001) begin bad++; $display("FAIL after_clear: got %h exp 0001", bus.Data); end
  endtask

  task automatic test_hold_through_clear();
    do_reset();
    @(negedge clk);
    bus.btn_up = 1'b1;
    repeat (N + 4) @(negedge clk);
    total++; if (bus.Data !== 16'h0001) begin bad++; $display("FAIL hold_first: got %h exp 0001", bus.Data); end
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    repeat (20) @(negedge clk);
    total++; if (bus.Data !== 16'h0000) begin bad++; $display("FAIL hold_clear: got %h exp 0000", bus.Data); end
    bus.btn_up = 1'b0;
    repeat (N + 5) @(negedge clk);
    press(1'b1, 1'b0);
    total++; if (bus.Data !== 16'h0001) begin bad++; $display("FAIL hold_repress: got %h exp 0001", bus.Data); end
  endtask

  task automatic test_reset_mid();
    int lat;
    do_reset();
    repeat (5) press(1'b1, 1'b0);
    total++; if (bus.Data !== 16'h0005) begin bad++; $display("FAIL preload_5: got %h exp 0005", bus.Data); end
    @(negedge clk);
    bus.btn_up = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total++; if (bus.up_state !== 2'd1) begin bad++; $display("FAIL mid_press_wait: got %0d exp 1", bus.up_state); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.Data !== 16'h0000) begin bad++; $display("FAIL async_reset: got %h exp 0000", bus.Data); end
    total++; if (bus.up_state !== 2'd0) begin bad++; $display("FAIL async_reset_state: got %0d exp 0", bus.up_state); end
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    lat = -1;
    for (int e = 1; e <= N + 10; e++) begin
      @(posedge clk);
      #1;
      if (lat < 0 && bus.Data === 16'h0001) lat = e;
    end
    total++; if (lat < N + 1 || lat > N + 4) begin bad++; $display("FAIL repress_latency: got %0d edges exp %0d..%0d", lat, N + 1, N + 4); end
    @(negedge clk);
    bus.btn_up = 1'b0;
    repeat (N + 5) @(negedge clk);
    total++; if (bus.Data !== 16'h0001) begin bad++; $display("FAIL repress_data: got %h exp 0001", bus.Data); end
  endtask

  task automatic test_random();
    int w0;
    int exp_wraps;
    int op;
    do_reset();
    w0 = wrap_cycles;
    exp_wraps = 0;
    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(0, 5);
      case (op)
        0, 1: begin
          bounce_press(1'b1, 1'b0);
          if (model == 9999) exp_wraps++;
          model = (model + 1) % 10000;
        end
        2, 3: begin
          bounce_press(1'b0, 1'b1);
          if (model == 0) exp_wraps++;
          model = (model + 9999) % 10000;
        end
        4: bounce_press(1'b1, 1'b1);
        default: begin
          @(negedge clk);
          bus.clear = 1'b1;
          @(negedge clk);
          bus.clear = 1'b0;
          @(negedge clk);
          model = 0;
        end
      endcase
      total++;
      if (bus.Data !== to_bcd(model)) begin
        bad++;
        $display("FAIL random_op%0d(kind %0d): got %h exp %h", k, op, bus.Data, to_bcd(model));
      end
    end
    total++; if (wrap_cycles - w0 !== exp_wraps) begin bad++; $display("FAIL random_wraps: got %0d exp %0d", wrap_cycles - w0, exp_wraps); end
  endtask

  initial begin
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b0;
    bus.clear = 1'b0;
    test_reset();
    test_single_press();
    test_bounce();
    test_carry();
    test_simultaneous();
    test_hold_through_clear();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
